// File: rtl/flash_seq_pkg.sv
// Shared constants and state type for the flash op sequencer.
// FLASH_SEQ_WRDI_EN adds the trailing write-disable command.
package flash_seq_pkg;

  localparam int CMD_ID   = 1;
  localparam int CMD_WREN = 2;
  localparam int CMD_WRDI = 3;
  localparam int CMD_PP   = 4;
  localparam int CMD_X4   = 5;
  localparam int CMD_READ = 6;
  localparam int CMD_RDSR = 7;
  localparam int CMD_SE   = 8;

  localparam int FIN_ID   = 0;
  localparam int FIN_REG  = 1;
  localparam int FIN_PROG = 2;
  localparam int FIN_RD   = 3;

  localparam int WIP_BIT  = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN_REQ,
    S_WREN_WAIT,
    S_OP_REQ,
    S_OP_WAIT,
    S_POLL_REQ,
    S_POLL_DATA,
    S_POLL_WAIT,
    S_POLL_GAP,
`ifdef FLASH_SEQ_WRDI_EN
    S_WRDI_REQ,
    S_WRDI_WAIT,
`endif
    S_DONE
  } seq_state_e;

  function automatic logic wip_of(logic [7:0] s);
    return s[WIP_BIT];
  endfunction

endpackage

// File: rtl/flash_op_sequencer_if.sv
// Command and status-byte side of spi_flash as seen by the sequencer.
// FLASH_SEQ_WRDI_EN does not change this interface.
interface flash_op_sequencer_if #(
  parameter int CSIZE = 4,
  parameter int LSIZE = 24,
  parameter int SLIZE = 16,
  parameter int NFIN  = 4
);
  logic             cmd_request;
  logic [CSIZE-1:0] cmd_code;
  logic [LSIZE-1:0] cmd_addr;
  logic [SLIZE-1:0] cmd_len;
  logic [NFIN-1:0]  cmd_finish;
  logic             st_valid;
  logic [7:0]       st_data;
  logic             st_ready;

  modport master (
    output cmd_request, cmd_code, cmd_addr, cmd_len,
    output st_ready,
    input  cmd_finish, st_valid, st_data
  );

  modport slave (
    input  cmd_request, cmd_code, cmd_addr, cmd_len,
    input  st_ready,
    output cmd_finish, st_valid, st_data
  );
endinterface

// File: rtl/flash_cmd_issuer.sv
// Issues one command: REQ_HOLD-cycle request, fields held until finish.
// FLASH_SEQ_WRDI_EN does not affect this block.
module flash_cmd_issuer #(
  parameter int CSIZE    = 4,
  parameter int LSIZE    = 24,
  parameter int SLIZE    = 16,
  parameter int NFIN     = 4,
  parameter int REQ_HOLD = 2,
  parameter int SW       = (NFIN > 1) ? $clog2(NFIN) : 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wait_en,
  input  logic [CSIZE-1:0] code,
  input  logic [LSIZE-1:0] addr,
  input  logic [SLIZE-1:0] len,
  input  logic [SW-1:0]    sel,
  input  logic [NFIN-1:0]  finish,
  output logic             cmd_request,
  output logic [CSIZE-1:0] cmd_code,
  output logic [LSIZE-1:0] cmd_addr,
  output logic [SLIZE-1:0] cmd_len,
  output logic             issued,
  output logic             fin_ok
);

  logic          busy;
  logic [7:0]    hold;
  logic [SW-1:0] sel_q;

  assign issued = cmd_request && (hold == '0);
  // finish is only honoured once the request pulse is over
  assign fin_ok = busy && !cmd_request && wait_en
               && finish[sel_q];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      hold        <= '0;
      sel_q       <= '0;
      cmd_request <= 1'b0;
      cmd_code    <= '0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
    end else if (start && !busy) begin
      busy        <= 1'b1;
      hold        <= 8'(REQ_HOLD - 1);
      sel_q       <= sel;
      cmd_request <= 1'b1;
      cmd_code    <= code;
      cmd_addr    <= addr;
      cmd_len     <= len;
    end else if (issued) begin
      cmd_request <= 1'b0;
    end else if (cmd_request) begin
      hold <= hold - 8'd1;
    end else if (fin_ok) begin
      busy     <= 1'b0;
      cmd_code <= '0;
      cmd_addr <= '0;
      cmd_len  <= '0;
    end
  end

endmodule

// File: rtl/flash_op_sequencer.sv
// Page program / sector erase sequencer in front of spi_flash.
// Define FLASH_SEQ_WRDI_EN to end every job with a write disable.
module flash_op_sequencer
  import flash_seq_pkg::*;
#(
  parameter int          CSIZE    = 4,
  parameter int          LSIZE    = 24,
  parameter int          SLIZE    = 16,
  parameter int          NFIN     = 4,
  parameter int          REQ_HOLD = 2,
  parameter int          POLL_GAP = 64,
  parameter logic [15:0] MAX_POLL = 16'hFFFF
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic             job_erase,
  input  logic [LSIZE-1:0] job_addr,
  input  logic [SLIZE-1:0] job_len,
  output logic             job_done,
  output logic             job_err,
  output logic [15:0]      job_polls,
  flash_op_sequencer_if.master bus
);

  localparam int SW = (NFIN > 1) ? $clog2(NFIN) : 1;
  localparam logic [SLIZE-1:0] PAGE = SLIZE'(256);
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
`ifdef FLASH_SEQ_WRDI_EN
  localparam seq_state_e S_END = S_WRDI_REQ;
`else
  localparam seq_state_e S_END = S_DONE;
`endif

  seq_state_e state, state_n;

  logic             ready_q;
  logic             erase_q;
  logic [LSIZE-1:0] addr_q;
  logic [SLIZE-1:0] len_q;
  logic [15:0]      polls;
  logic [15:0]      gap_cnt;
  logic             wip_q;
  logic             err_q;

  logic             start;
  logic             wait_en;
  logic [CSIZE-1:0] code;
  logic [LSIZE-1:0] addr;
  logic [SLIZE-1:0] len;
  logic [SW-1:0]    sel;
  logic             issued;
  logic             fin_ok;
  logic             accept;
  logic             take;
  logic             timeout;

  assign job_ready    = ready_q;
  assign accept       = job_valid && ready_q;
  assign bus.st_ready = (state == S_POLL_DATA);
  assign take         = bus.st_valid && bus.st_ready
                     && clk_en;
  assign timeout      = wip_q && (polls == MAX_POLL);
  assign job_done     = (state == S_DONE);
  assign job_err      = job_done && err_q;

  flash_cmd_issuer #(
    .CSIZE    (CSIZE),
    .LSIZE    (LSIZE),
    .SLIZE    (SLIZE),
    .NFIN     (NFIN),
    .REQ_HOLD (REQ_HOLD),
    .SW       (SW)
  ) u_issuer (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .wait_en     (wait_en),
    .code        (code),
    .addr        (addr),
    .len         (len),
    .sel         (sel),
    .finish      (bus.cmd_finish),
    .cmd_request (bus.cmd_request),
    .cmd_code    (bus.cmd_code),
    .cmd_addr    (bus.cmd_addr),
    .cmd_len     (bus.cmd_len),
    .issued      (issued),
    .fin_ok      (fin_ok)
  );

  always_comb begin
    state_n = state;
    start   = 1'b0;
    wait_en = 1'b0;
    code    = '0;
    addr    = '0;
    len     = '0;
    sel     = SW'(FIN_REG);
    unique case (state)
      S_IDLE:
        if (accept) state_n = S_WREN_REQ;
      S_WREN_REQ: begin
        start = 1'b1;
        code  = CSIZE'(CMD_WREN);
        if (issued) state_n = S_WREN_WAIT;
      end
      S_WREN_WAIT: begin
        wait_en = 1'b1;
        if (fin_ok) state_n = S_OP_REQ;
      end
      S_OP_REQ: begin
        start = 1'b1;
        code  = erase_q ? CSIZE'(CMD_SE)
                        : CSIZE'(CMD_PP);
        addr  = addr_q;
        len   = erase_q ? '0 : len_q;
        sel   = SW'(FIN_PROG);
        if (issued) state_n = S_OP_WAIT;
      end
      S_OP_WAIT: begin
        wait_en = 1'b1;
        if (fin_ok) state_n = S_POLL_REQ;
      end
      S_POLL_REQ: begin
        start = 1'b1;
        code  = CSIZE'(CMD_RDSR);
        len   = SLIZE'(1);
        if (issued) state_n = S_POLL_DATA;
      end
      S_POLL_DATA:
        if (take) state_n = S_POLL_WAIT;
      S_POLL_WAIT: begin
        wait_en = 1'b1;
        if (fin_ok) begin
          if (!wip_q || timeout) state_n = S_END;
          else                   state_n = S_POLL_GAP;
        end
      end
      S_POLL_GAP:
        if (clk_en && gap_cnt == GAP_LAST)
          state_n = S_POLL_REQ;
`ifdef FLASH_SEQ_WRDI_EN
      S_WRDI_REQ: begin
        start = 1'b1;
        code  = CSIZE'(CMD_WRDI);
        if (issued) state_n = S_WRDI_WAIT;
      end
      S_WRDI_WAIT: begin
        wait_en = 1'b1;
        if (fin_ok) state_n = S_DONE;
      end
`endif
      S_DONE:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ready_q   <= 1'b0;
      erase_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      polls     <= '0;
      gap_cnt   <= '0;
      wip_q     <= 1'b0;
      err_q     <= 1'b0;
      job_polls <= '0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n == S_IDLE);
      if (state == S_IDLE && accept) begin
        erase_q <= job_erase;
        addr_q  <= job_addr;
        len_q   <= (job_len > PAGE) ? PAGE : job_len;
        polls   <= '0;
        gap_cnt <= '0;
        err_q   <= 1'b0;
      end
      if (take) begin
        wip_q <= wip_of(bus.st_data);
        if (polls != MAX_POLL) polls <= polls + 16'd1;
      end
      if (state == S_POLL_WAIT && fin_ok && timeout)
        err_q <= 1'b1;
      if (state == S_POLL_GAP && clk_en)
        gap_cnt <= (gap_cnt == GAP_LAST) ? '0
                 : gap_cnt + 16'd1;
      if (state == S_DONE)
        job_polls <= polls;
    end
  end

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Directed bench for flash_op_sequencer with a simple spi_flash responder.
// Expected command lists include code 3 only when FLASH_SEQ_WRDI_EN is set.
module tb_flash_op_sequencer;
  import flash_seq_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_erase = 1'b0;
  logic [23:0] job_addr = '0;
  logic [15:0] job_len = '0;
  logic        job_ready;
  logic        job_done;
  logic        job_err;
  logic [15:0] job_polls;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int fin_cyc = 0;
  int done_cnt = 0;

  int          code_q[$];
  logic [23:0] addr_q[$];
  logic [15:0] len_q[$];
  int          wid_q[$];
  int          exp_q[$];
  logic [7:0]  stat_q[$];
  logic [7:0]  stat_dflt = 8'h00;

  flash_op_sequencer_if #(
    .CSIZE(4), .LSIZE(24), .SLIZE(16), .NFIN(4)
  ) bus ();

  flash_op_sequencer #(
    .REQ_HOLD (2),
    .POLL_GAP (4),
    .MAX_POLL (16'd4)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_erase (job_erase),
    .job_addr  (job_addr),
    .job_len   (job_len),
    .job_done  (job_done),
    .job_err   (job_err),
    .job_polls (job_polls),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock)
    if (job_done === 1'b1) done_cnt++;

  function automatic int fin_of(int c);
    if (c == CMD_PP || c == CMD_SE) return FIN_PROG;
    if (c == CMD_READ) return FIN_RD;
    if (c == CMD_ID) return FIN_ID;
    return FIN_REG;
  endfunction

  // flash model: log each request, answer RDSR, raise finish later
  int req_seen = 0;
  int wid = 0;
  int dly = 0;
  int grp = 0;
  int st_go = 0;
  always @(negedge clock) begin
    if (!rst_n) begin
      bus.cmd_finish = '0;
      bus.st_valid = 1'b0;
      bus.st_data = '0;
      req_seen = 0;
      dly = 0;
      st_go = 0;
    end else begin
      if (st_go != 0) begin
        bus.st_valid = 1'b0;
        st_go = 0;
      end else if (bus.st_valid && bus.st_ready) begin
        st_go = 1;
      end
      if (bus.cmd_request && req_seen == 0) begin
        req_seen = 1;
        wid = 1;
        code_q.push_back(int'(bus.cmd_code));
        addr_q.push_back(bus.cmd_addr);
        len_q.push_back(bus.cmd_len);
        grp = fin_of(int'(bus.cmd_code));
        bus.cmd_finish[grp] = 1'b0;
        if (int'(bus.cmd_code) == CMD_RDSR) begin
          bus.st_data = (stat_q.size() > 0)
                      ? stat_q.pop_front() : stat_dflt;
          bus.st_valid = 1'b1;
        end
      end else if (bus.cmd_request) begin
        wid++;
      end else if (req_seen != 0) begin
        req_seen = 0;
        wid_q.push_back(wid);
        dly = 3;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          bus.cmd_finish[grp] = 1'b1;
          fin_cyc = cyc;
        end
      end
    end
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    code_q.delete();
    addr_q.delete();
    len_q.delete();
    wid_q.delete();
    exp_q.delete();
    stat_q.delete();
  endtask

  task automatic start_job(logic e, logic [23:0] a,
                           logic [15:0] l);
    int n = 0;
    @(negedge clock);
    while (job_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", 32'(job_ready), 1);
    job_valid = 1'b1;
    job_erase = e;
    job_addr = a;
    job_len = l;
    @(negedge clock);
    job_valid = 1'b0;
    chk("ready_busy", 32'(job_ready), 0);
  endtask

  task automatic wait_done(string tag, logic exp_err,
                           logic [15:0] exp_polls);
    int n = 0;
    int dcyc;
    while (job_done !== 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_done"}, 32'(job_done), 1);
    chk({tag, "_err"}, 32'(job_err), 32'(exp_err));
    dcyc = cyc;
    chk({tag, "_lat"}, 32'(dcyc - fin_cyc), 1);
    @(negedge clock);
    chk({tag, "_pulse"}, 32'(job_done), 0);
    chk({tag, "_polls"}, 32'(job_polls), 32'(exp_polls));
  endtask

  task automatic check_codes(string tag);
`ifdef FLASH_SEQ_WRDI_EN
    exp_q.push_back(CMD_WRDI);
`endif
    chk({tag, "_ncmd"}, 32'(code_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < code_q.size(); i++)
      chk($sformatf("%s_code%0d", tag, i),
          32'(code_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int d0;
    int n;
    #1;
    chk("rst_ready", 32'(job_ready), 0);
    chk("rst_done", 32'(job_done), 0);
    chk("rst_req", 32'(bus.cmd_request), 0);
    chk("rst_st_ready", 32'(bus.st_ready), 0);
    chk("rst_polls", 32'(job_polls), 0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", 32'(job_ready), 1);

    // page program, WIP clears on third status byte
    clear_logs();
    stat_q = '{8'h03, 8'h03, 8'h00};
    start_job(1'b0, 24'h001000, 16'd256);
    wait_done("pp", 1'b0, 16'd3);
    exp_q = '{CMD_WREN, CMD_PP, CMD_RDSR, CMD_RDSR, CMD_RDSR};
    check_codes("pp");
    chk("pp_addr", 32'(addr_q[1]), 32'h001000);
    chk("pp_len", 32'(len_q[1]), 256);
    chk("pp_rdsr_len", 32'(len_q[2]), 1);
    chk("pp_req_width", 32'(wid_q[0]), 2);

    // sector erase, idle on first status byte
    clear_logs();
    stat_q = '{8'h00};
    start_job(1'b1, 24'h020000, 16'h0055);
    wait_done("se", 1'b0, 16'd1);
    exp_q = '{CMD_WREN, CMD_SE, CMD_RDSR};
    check_codes("se");
    chk("se_addr", 32'(addr_q[1]), 32'h020000);

    // status stuck busy: MAX_POLL polls then timeout
    clear_logs();
    stat_dflt = 8'h01;
    start_job(1'b0, 24'h000100, 16'd16);
    wait_done("to", 1'b1, 16'd4);
    exp_q = '{CMD_WREN, CMD_PP, CMD_RDSR, CMD_RDSR,
              CMD_RDSR, CMD_RDSR};
    check_codes("to");
    chk("to_len16", 32'(len_q[1]), 16);
    stat_dflt = 8'h00;

    // oversize length is clamped to one page
    clear_logs();
    stat_q = '{8'h00};
    start_job(1'b0, 24'h003000, 16'h0400);
    wait_done("clamp", 1'b0, 16'd1);
    chk("clamp_len", 32'(len_q[1]), 256);

    // reset while waiting for the program finish
    clear_logs();
    start_job(1'b0, 24'h004000, 16'd8);
    n = 0;
    while ((code_q.size() < 2 || bus.cmd_request)
           && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("abort_in_op", 32'(code_q.size()), 2);
    @(negedge clock);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_code", 32'(bus.cmd_code), 0);
    chk("abort_req", 32'(bus.cmd_request), 0);
    chk("abort_addr", 32'(bus.cmd_addr), 0);
    chk("abort_ready", 32'(job_ready), 0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));

    clear_logs();
    stat_q = '{8'h00};
    start_job(1'b1, 24'h030000, 16'd0);
    wait_done("post", 1'b0, 16'd1);
    chk("post_addr", 32'(addr_q[1]), 32'h030000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
